// File: rtl/main_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit and its ALU decoder.
// The ERROR state only exists when ILLEGAL_TRAP_EN is defined.
package main_control_fsm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
`ifdef ILLEGAL_TRAP_EN
        ,
        ERROR    = 4'd11
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format depends only on the opcode, never on the FSM state.
    function automatic logic [1:0] imm_decode(input logic [6:0] op);
        logic [1:0] imm;
        imm = IMM_I;
        case (op)
            OP_LOAD, OP_ITYPE: imm = IMM_I;
            OP_STORE:          imm = IMM_S;
            OP_BRANCH:         imm = IMM_B;
            OP_JAL:            imm = IMM_J;
            default:           imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/main_control_fsm_alu_decoder.sv
// Combinational ALU operation decode from aluop and the funct fields.
// op5 separates R-type sub from I-type addi, which has no subtract form.
module alu_decoder
    import main_control_fsm_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default:   alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle RISC-V control FSM (lw, sw, R/I ALU, beq, jal) with mem_ready stalls.
// Define ILLEGAL_TRAP_EN to trap unsupported opcodes in a sticky ERROR state.
module main_control_fsm
    import main_control_fsm_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               adrsrc,
    output logic               memwrite,
    output logic               irwrite,
    output logic [1:0]         resultsrc,
    output logic [1:0]         alusrca,
    output logic [1:0]         alusrcb,
    output logic [2:0]         alucontrol,
    output logic [1:0]         immsrc,
    output logic               regwrite,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] state_dbg
);

    state_t     state;
    logic [1:0] aluop;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state <= MEMADR;
                        OP_RTYPE:          state <= EXECUTER;
                        OP_ITYPE:          state <= EXECUTEI;
                        OP_BRANCH:         state <= BEQ;
                        OP_JAL:            state <= JAL;
`ifdef ILLEGAL_TRAP_EN
                        default:           state <= ERROR;
`else
                        // PC was already advanced in FETCH, so this is a NOP.
                        default:           state <= FETCH;
`endif
                    endcase
                end
                MEMADR:   state <= (op == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (mem_ready) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: if (mem_ready) state <= FETCH;
                EXECUTER: state <= ALUWB;
                EXECUTEI: state <= ALUWB;
                ALUWB:    state <= FETCH;
                BEQ:      state <= FETCH;
                JAL:      state <= ALUWB;
`ifdef ILLEGAL_TRAP_EN
                ERROR:    state <= ERROR;
`endif
                default:  state <= FETCH;
            endcase
        end
    end

    // Outputs decode straight from state so reset can gate writes in the same cycle.
    always_comb begin
        pcwrite   = 1'b0;
        adrsrc    = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        resultsrc = RES_ALUOUT;
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_RS2;
        aluop     = ALUOP_ADD;
        if (!resetn) begin
            alusrcb   = SRCB_FOUR;
            resultsrc = RES_ALURESULT;
        end else begin
            case (state)
                FETCH: begin
                    alusrcb   = SRCB_FOUR;
                    resultsrc = RES_ALURESULT;
                    irwrite   = mem_ready;
                    pcwrite   = mem_ready;
                end
                DECODE: begin
                    alusrca = SRCA_OLDPC;
                    alusrcb = SRCB_IMM;
                end
                MEMADR: begin
                    alusrca = SRCA_RS1;
                    alusrcb = SRCB_IMM;
                end
                MEMREAD: begin
                    adrsrc = 1'b1;
                end
                MEMWB: begin
                    resultsrc = RES_DATA;
                    regwrite  = 1'b1;
                end
                MEMWRITE: begin
                    adrsrc   = 1'b1;
                    memwrite = 1'b1;
                end
                EXECUTER: begin
                    alusrca = SRCA_RS1;
                    alusrcb = SRCB_RS2;
                    aluop   = ALUOP_FUNCT;
                end
                EXECUTEI: begin
                    alusrca = SRCA_RS1;
                    alusrcb = SRCB_IMM;
                    aluop   = ALUOP_FUNCT;
                end
                ALUWB: begin
                    regwrite = 1'b1;
                end
                BEQ: begin
                    alusrca = SRCA_RS1;
                    alusrcb = SRCB_RS2;
                    aluop   = ALUOP_SUB;
                    pcwrite = zero;
                end
                JAL: begin
                    alusrca = SRCA_OLDPC;
                    alusrcb = SRCB_FOUR;
                    pcwrite = 1'b1;
                end
                default: begin
                    pcwrite = 1'b0;
                end
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = resetn && (state == ERROR);
`else
    assign illegal_instr = 1'b0;
`endif

    assign immsrc    = imm_decode(op);
    assign state_dbg = STATE_W'(state);

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: per-instruction state walks, stalls, reset and illegal ops.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal_instr;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;
    logic [3:0] state_dbg;

    int pass_cnt = 0;
    int total_cnt = 0;

    main_control_fsm #(.STATE_W(4)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pcwrite       (pcwrite),
        .adrsrc        (adrsrc),
        .memwrite      (memwrite),
        .irwrite       (irwrite),
        .resultsrc     (resultsrc),
        .alusrca       (alusrca),
        .alusrcb       (alusrcb),
        .alucontrol    (alucontrol),
        .immsrc        (immsrc),
        .regwrite      (regwrite),
        .illegal_instr (illegal_instr),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] ins);
        op       = ins[6:0];
        funct3   = ins[14:12];
        funct7b5 = ins[30];
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        mem_ready = 1'b1;
        step;
        step;
        total_cnt++; if (state_dbg !== 4'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else pass_cnt++;
        total_cnt++; if ({pcwrite, irwrite, regwrite, memwrite, illegal_instr} !== 5'b0)
            $display("FAIL reset_enables: got %b want 00000", {pcwrite, irwrite, regwrite, memwrite, illegal_instr}); else pass_cnt++;
        total_cnt++; if ({adrsrc, alusrca, alusrcb, resultsrc, alucontrol} !== {1'b0, 2'b00, 2'b10, 2'b10, 3'b000})
            $display("FAIL reset_selects: got %b want 0001010000", {adrsrc, alusrca, alusrcb, resultsrc, alucontrol}); else pass_cnt++;
        resetn = 1'b1;
        #1;
        total_cnt++; if ({pcwrite, irwrite} !== 2'b11) $display("FAIL fetch_enables: got %b want 11", {pcwrite, irwrite}); else pass_cnt++;
    endtask

    task automatic test_lw;
        logic [3:0] exp_st [5];
        logic       exp_rw;
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        mem_ready = 1'b1;
        set_instr(32'h00402083);
        total_cnt++; if (immsrc !== 2'b00) $display("FAIL lw_immsrc: got %b want 00", immsrc); else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            exp_rw = (c == 4);
            total_cnt++; if (state_dbg !== exp_st[c]) $display("FAIL lw_state c%0d: got %0d want %0d", c, state_dbg, exp_st[c]); else pass_cnt++;
            total_cnt++; if (regwrite !== exp_rw) $display("FAIL lw_regwrite c%0d: got %b want %b", c, regwrite, exp_rw); else pass_cnt++;
            if (c == 2) begin
                total_cnt++; if ({alusrca, alusrcb, alucontrol} !== 7'b1001000)
                    $display("FAIL lw_memadr_sel: got %b want 1001000", {alusrca, alusrcb, alucontrol}); else pass_cnt++;
            end
            if (c == 3) begin
                total_cnt++; if (adrsrc !== 1'b1) $display("FAIL lw_adrsrc: got %b want 1", adrsrc); else pass_cnt++;
            end
            if (c == 4) begin
                total_cnt++; if (resultsrc !== 2'b01) $display("FAIL lw_resultsrc: got %b want 01", resultsrc); else pass_cnt++;
            end
            step;
        end
        total_cnt++; if (state_dbg !== 4'd0) $display("FAIL lw_end_state: got %0d want 0", state_dbg); else pass_cnt++;
    endtask

    task automatic test_sw;
        logic [3:0] exp_st [4];
        logic       exp_mw;
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd5};
        mem_ready = 1'b1;
        set_instr(32'h0010A223);
        total_cnt++; if (immsrc !== 2'b01) $display("FAIL sw_immsrc: got %b want 01", immsrc); else pass_cnt++;
        for (int c = 0; c < 4; c++) begin
            exp_mw = (c == 3);
            total_cnt++; if (state_dbg !== exp_st[c]) $display("FAIL sw_state c%0d: got %0d want %0d", c, state_dbg, exp_st[c]); else pass_cnt++;
            total_cnt++; if ({memwrite, regwrite} !== {exp_mw, 1'b0})
                $display("FAIL sw_writes c%0d: got %b want %b0", c, {memwrite, regwrite}, exp_mw); else pass_cnt++;
            if (c == 3) begin
                total_cnt++; if (adrsrc !== 1'b1) $display("FAIL sw_adrsrc: got %b want 1", adrsrc); else pass_cnt++;
            end
            step;
        end
        total_cnt++; if (state_dbg !== 4'd0) $display("FAIL sw_end_state: got %0d want 0", state_dbg); else pass_cnt++;
    endtask

    // Runs an R/I-type instruction through FETCH, DECODE, EXECUTE*, ALUWB.
    task automatic run_alu_instr(input logic [31:0] ins, input logic [3:0] exec_st,
                                 input logic [2:0] exp_alu, input logic [1:0] exp_srcb);
        mem_ready = 1'b1;
        set_instr(ins);
        step;
        total_cnt++; if (state_dbg !== 4'd1) $display("FAIL alu_decode_state %h: got %0d want 1", ins, state_dbg); else pass_cnt++;
        step;
        total_cnt++; if (state_dbg !== exec_st) $display("FAIL alu_exec_state %h: got %0d want %0d", ins, state_dbg, exec_st); else pass_cnt++;
        total_cnt++; if ({alucontrol, alusrca, alusrcb} !== {exp_alu, 2'b10, exp_srcb})
            $display("FAIL alu_exec_ctrl %h: got %b want %b", ins, {alucontrol, alusrca, alusrcb}, {exp_alu, 2'b10, exp_srcb}); else pass_cnt++;
        step;
        total_cnt++; if ({state_dbg, regwrite, resultsrc} !== {4'd8, 1'b1, 2'b00})
            $display("FAIL alu_wb %h: got %b want 1000100", ins, {state_dbg, regwrite, resultsrc}); else pass_cnt++;
        step;
        total_cnt++; if (state_dbg !== 4'd0) $display("FAIL alu_end_state %h: got %0d want 0", ins, state_dbg); else pass_cnt++;
    endtask

    task automatic test_rtype;
        run_alu_instr(32'h402081B3, 4'd6, 3'b001, 2'b00);
        run_alu_instr(32'h002081B3, 4'd6, 3'b000, 2'b00);
        run_alu_instr(32'h0020E1B3, 4'd6, 3'b011, 2'b00);
    endtask

    task automatic test_itype;
        run_alu_instr(32'h40000093, 4'd7, 3'b000, 2'b01);
        run_alu_instr(32'h00006093, 4'd7, 3'b011, 2'b01);
        run_alu_instr(32'h00007093, 4'd7, 3'b010, 2'b01);
        run_alu_instr(32'h00002093, 4'd7, 3'b101, 2'b01);
    endtask

    task automatic test_beq;
        logic z;
        for (int k = 0; k < 2; k++) begin
            z = (k == 0);
            mem_ready = 1'b1;
            zero = z;
            set_instr(32'h00000463);
            total_cnt++; if (immsrc !== 2'b10) $display("FAIL beq_immsrc: got %b want 10", immsrc); else pass_cnt++;
            step;
            total_cnt++; if ({state_dbg, pcwrite} !== {4'd1, 1'b0}) $display("FAIL beq_decode: got %b want 00010", {state_dbg, pcwrite}); else pass_cnt++;
            step;
            total_cnt++; if ({state_dbg, alucontrol} !== {4'd9, 3'b001}) $display("FAIL beq_state_alu: got %b want 1001001", {state_dbg, alucontrol}); else pass_cnt++;
            total_cnt++; if (pcwrite !== z) $display("FAIL beq_pcwrite zero=%b: got %b want %b", z, pcwrite, z); else pass_cnt++;
            step;
            total_cnt++; if (state_dbg !== 4'd0) $display("FAIL beq_end_state: got %0d want 0", state_dbg); else pass_cnt++;
        end
        zero = 1'b0;
    endtask

    task automatic test_jal;
        mem_ready = 1'b1;
        set_instr(32'h0000006F);
        total_cnt++; if (immsrc !== 2'b11) $display("FAIL jal_immsrc: got %b want 11", immsrc); else pass_cnt++;
        step;
        step;
        total_cnt++; if ({state_dbg, pcwrite, alusrca, alusrcb, resultsrc} !== {4'd10, 1'b1, 2'b01, 2'b10, 2'b00})
            $display("FAIL jal_ctrl: got %b want 1010101100", {state_dbg, pcwrite, alusrca, alusrcb, resultsrc}); else pass_cnt++;
        step;
        total_cnt++; if ({state_dbg, regwrite} !== {4'd8, 1'b1}) $display("FAIL jal_wb: got %b want 10001", {state_dbg, regwrite}); else pass_cnt++;
        step;
        total_cnt++; if (state_dbg !== 4'd0) $display("FAIL jal_end_state: got %0d want 0", state_dbg); else pass_cnt++;
    endtask

    task automatic test_fetch_stall;
        mem_ready = 1'b0;
        set_instr(32'h402081B3);
        for (int c = 0; c < 3; c++) begin
            total_cnt++; if ({state_dbg, irwrite, pcwrite} !== {4'd0, 2'b00})
                $display("FAIL stall_fetch c%0d: got %b want 000000", c, {state_dbg, irwrite, pcwrite}); else pass_cnt++;
            step;
        end
        mem_ready = 1'b1;
        #1;
        total_cnt++; if ({irwrite, pcwrite} !== 2'b11) $display("FAIL stall_release: got %b want 11", {irwrite, pcwrite}); else pass_cnt++;
        step;
        total_cnt++; if (state_dbg !== 4'd1) $display("FAIL stall_decode: got %0d want 1", state_dbg); else pass_cnt++;
        step;
        step;
        step;
        total_cnt++; if (state_dbg !== 4'd0) $display("FAIL stall_end_state: got %0d want 0", state_dbg); else pass_cnt++;
    endtask

    task automatic test_memread_stall;
        mem_ready = 1'b1;
        set_instr(32'h00402083);
        step;
        step;
        step;
        mem_ready = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            step;
            total_cnt++; if ({state_dbg, regwrite} !== {4'd3, 1'b0}) $display("FAIL memread_hold c%0d: got %b want 00110", c, {state_dbg, regwrite}); else pass_cnt++;
        end
        mem_ready = 1'b1;
        step;
        total_cnt++; if (state_dbg !== 4'd4) $display("FAIL memread_release: got %0d want 4", state_dbg); else pass_cnt++;
        step;
    endtask

    task automatic test_reset_memwrite;
        mem_ready = 1'b1;
        set_instr(32'h0010A223);
        step;
        step;
        step;
        mem_ready = 1'b0;
        #1;
        total_cnt++; if ({state_dbg, memwrite} !== {4'd5, 1'b1}) $display("FAIL mw_wait: got %b want 01011", {state_dbg, memwrite}); else pass_cnt++;
        step;
        total_cnt++; if ({state_dbg, memwrite} !== {4'd5, 1'b1}) $display("FAIL mw_hold: got %b want 01011", {state_dbg, memwrite}); else pass_cnt++;
        resetn = 1'b0;
        #1;
        total_cnt++; if ({memwrite, adrsrc} !== 2'b00) $display("FAIL mw_reset_gate: got %b want 00", {memwrite, adrsrc}); else pass_cnt++;
        step;
        total_cnt++; if (state_dbg !== 4'd0) $display("FAIL mw_reset_state: got %0d want 0", state_dbg); else pass_cnt++;
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_illegal;
        mem_ready = 1'b1;
        set_instr(32'h0000000F);
        total_cnt++; if (immsrc !== 2'b00) $display("FAIL ill_immsrc: got %b want 00", immsrc); else pass_cnt++;
        step;
        total_cnt++; if (state_dbg !== 4'd1) $display("FAIL ill_decode: got %0d want 1", state_dbg); else pass_cnt++;
        step;
`ifdef ILLEGAL_TRAP_EN
        for (int c = 0; c < 3; c++) begin
            total_cnt++; if ({state_dbg, illegal_instr, pcwrite, irwrite, regwrite, memwrite} !== {4'd11, 5'b10000})
                $display("FAIL ill_error c%0d: got %b want 101110000", c, {state_dbg, illegal_instr, pcwrite, irwrite, regwrite, memwrite}); else pass_cnt++;
            step;
        end
        resetn = 1'b0;
        #1;
        total_cnt++; if (illegal_instr !== 1'b0) $display("FAIL ill_reset_flag: got %b want 0", illegal_instr); else pass_cnt++;
        step;
        resetn = 1'b1;
        #1;
        total_cnt++; if (state_dbg !== 4'd0) $display("FAIL ill_recover: got %0d want 0", state_dbg); else pass_cnt++;
`else
        total_cnt++; if ({state_dbg, illegal_instr} !== {4'd0, 1'b0}) $display("FAIL ill_nop: got %b want 00000", {state_dbg, illegal_instr}); else pass_cnt++;
        step;
        total_cnt++; if ({state_dbg, illegal_instr} !== {4'd1, 1'b0}) $display("FAIL ill_refetch: got %b want 00010", {state_dbg, illegal_instr}); else pass_cnt++;
        step;
        step;
`endif
    endtask

    initial begin
        test_reset;
        test_lw;
        test_sw;
        test_rtype;
        test_itype;
        test_beq;
        test_jal;
        test_fetch_stall;
        test_memread_stall;
        test_reset_memwrite;
        test_illegal;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
Name: main_control_fsm

Overview:
- Multi-cycle RISC-V control unit. Sits directly upstream of the immediate extender, the ALU and the datapath muxes.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Decodes the opcode into immsrc for the extender.
- Generates every datapath enable and mux select.
- Stalls on a memory ready handshake.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal.

Parameters:
- STATE_W, 4, width of the state register and of the debug state port.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous, active-low reset
- op  input  7  instr[6:0]
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes access this cycle
- pcwrite  output  1  PC register enable
- adrsrc  output  1  memory address select: 0=PC, 1=ALUOut
- memwrite  output  1  data memory write strobe
- irwrite  output  1  instruction/oldPC register enable
- resultsrc  output  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- alusrca  output  2  ALU A select: 00=PC, 01=oldPC, 10=rs1
- alusrcb  output  2  ALU B select: 00=rs2, 01=immext, 10=4
- alucontrol  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- immsrc  output  2  00 I, 01 S, 10 B, 11 J (feeds extender)
- regwrite  output  1  register file write enable
- illegal_instr  output  1  unsupported opcode seen
- state_dbg  output  STATE_W  current state

Behaviour:
- Moore FSM. All outputs are combinational from the state (plus op/funct/zero/mem_ready where noted). State updates on the rising edge of clk.
- While resetn=0:
  - next state = FETCH.
  - pcwrite, irwrite, regwrite, memwrite and illegal_instr are forced to 0.
  - Selects take their FETCH values.
- FETCH: adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10.
  - irwrite and pcwrite are asserted only when mem_ready=1.
  - Transition to DECODE on mem_ready=1; otherwise hold.
- DECODE: alusrca=01, alusrcb=01, aluop=00 (branch/jump target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> see Optional Feature
- MEMADR: alusrca=10, alusrcb=01, aluop=00. Next state is MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adrsrc=1, resultsrc=00. Hold until mem_ready=1, then MEMWB.
- MEMWB: resultsrc=01, regwrite=1, then FETCH.
- MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1. memwrite stays high while waiting. On mem_ready=1 -> FETCH.
- EXECUTER: alusrca=10, alusrcb=00, aluop=10, then ALUWB.
- EXECUTEI: alusrca=10, alusrcb=01, aluop=10, then ALUWB.
- ALUWB: resultsrc=00, regwrite=1, then FETCH.
- BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, pcwrite=zero, then FETCH.
- JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcwrite=1, then ALUWB.
- Unlisted outputs are 0 in every state.
- immsrc is pure combinational decode of op, independent of state:
  - 0000011, 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - other -> 00
- ALU decode from aluop:
  - aluop 00 -> add
  - aluop 01 -> sub
  - aluop 10, by funct3:
    - 000 -> sub if op[5] & funct7b5, else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - other -> add
- Cycle counts with mem_ready=1 throughout: lw 5, sw 4, R/I 4, beq 3, jal 4.
- Each mem_ready=0 cycle adds one stall cycle in FETCH, MEMREAD or MEMWRITE.
- Reset asserted mid-instruction: FETCH on the next edge. No partial writes are issued in the reset cycle.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unsupported op in DECODE -> ERROR state. ERROR drives illegal_instr=1 with all enables 0, and holds until reset.
- Undefined: an unsupported op in DECODE -> FETCH, so it acts as a NOP (PC already advanced). illegal_instr is tied to 0 and the ERROR state is absent.

Decomposition:
- Shared package holds:
  - state encodings (FETCH=0 through JAL=10, ERROR=11)
  - opcode constants
  - immsrc, resultsrc, alusrca and alusrcb encodings
  - alucontrol codes
- One combinational sub-module, alu_decoder (aluop, funct3, op5, funct7b5 -> alucontrol), instantiated inside main_control_fsm.

Test Plan:
- lw 0x00402083, mem_ready=1 -> states 0,1,2,3,4,0. immsrc=00. regwrite=1 only in cycle 5 with resultsrc=01.
- sw 0x0010A223 -> immsrc=01. memwrite=1 and adrsrc=1 in cycle 4. regwrite never asserted.
- sub 0x402081B3 -> EXECUTER with alucontrol=001, then ALUWB with regwrite=1. The same instruction with funct7b5=0 gives alucontrol=000.
- beq 0x00000463 -> immsrc=10. BEQ: alucontrol=001; with zero=1, pcwrite=1; repeat with zero=0, pcwrite=0.
- mem_ready held 0 for 3 cycles in FETCH -> irwrite=0 and state=FETCH for 3 cycles; DECODE in the cycle after mem_ready rises.
- resetn=0 during MEMWRITE -> memwrite=0 that cycle, state=FETCH next.
- Op 0001111:
  - ILLEGAL_TRAP_EN defined: ERROR state, illegal_instr=1 and held until reset.
  - Undefined: returns to FETCH after DECODE.
